// File: rtl/layer_compositor.sv
// Two-stage video compositor: picks overlay / keyed sprite / background, lays the HUD on top,
// then applies a frame-driven flash/fade effect to the non-HUD pixels before the colour outputs.
module layer_compositor #(
    parameter int                NUM_LAYERS       = 4,
    parameter int                CW               = 4,
    parameter logic [3*CW-1:0]   KEY_COLOR        = '0,
    parameter int                FLASH_FRAMES     = 8,
    parameter int                FADE_STEP_FRAMES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       video_on,
    input  logic                       frame_start,
    input  logic [NUM_LAYERS*3*CW-1:0] layer_pixels,
    input  logic [3*CW-1:0]            bg_pixel,
    input  logic [3*CW:0]              overlay_pixel,
    input  logic [1:0]                 health_disp,
    input  logic                       score_disp,
    input  logic                       hit_pulse,
    input  logic                       fade_req,
    input  logic                       fade_clr,
    output logic [CW-1:0]              vga_red,
    output logic [CW-1:0]              vga_green,
    output logic [CW-1:0]              vga_blue,
    output logic [1:0]                 fx_state
);

    localparam int PW  = 3 * CW;
    localparam int FLW = $clog2(FLASH_FRAMES + 1);
    localparam int STW = $clog2(FADE_STEP_FRAMES + 1);

    localparam logic [FLW-1:0] FLASH_LOAD = FLW'(FLASH_FRAMES);
    localparam logic [STW-1:0] STEP_LAST  = STW'(FADE_STEP_FRAMES - 1);
    localparam logic [CW-1:0]  LEVEL_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLASH = 2'd1,
        FADE  = 2'd2,
        BLACK = 2'd3
    } fx_t;

    fx_t            state;
    logic [FLW-1:0] flash_cnt;
    logic [STW-1:0] step_cnt;
    logic [CW-1:0]  fade_level;

    // HUD colours are written as 4-bit values and MSB-aligned to the channel width.
    function automatic logic [CW-1:0] hud_chan(input logic [3:0] v);
        logic [CW+3:0] wide;
        wide = {v, {CW{1'b0}}};
        return wide[CW+3 -: CW];
    endfunction

    function automatic logic [CW-1:0] sat_sub(input logic [CW-1:0] c, input logic [CW-1:0] lvl);
        logic signed [CW+1:0] d;
        d = $signed({2'b00, c}) - $signed({2'b00, lvl});
        return (d < 0) ? '0 : d[CW-1:0];
    endfunction

    // ---- stage 1: base select and HUD decode ----
    logic [PW-1:0] base_sel;
    logic          hud_sel;
    logic [PW-1:0] hud_col_sel;

    always_comb begin
        base_sel = bg_pixel;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_pixels[i*PW +: PW] != KEY_COLOR)
                base_sel = layer_pixels[i*PW +: PW];
        end
        if (overlay_pixel[PW])
            base_sel = overlay_pixel[PW-1:0];

        hud_sel     = score_disp | (|health_disp);
        hud_col_sel = '0;
        if (score_disp)
            hud_col_sel = {hud_chan(4'hD), hud_chan(4'hC), hud_chan(4'h0)};
        else begin
            case (health_disp)
                2'b11:   hud_col_sel = {hud_chan(4'h0), hud_chan(4'hF), hud_chan(4'h0)};
                2'b10:   hud_col_sel = {hud_chan(4'hD), hud_chan(4'h8), hud_chan(4'h0)};
                2'b01:   hud_col_sel = {hud_chan(4'hF), hud_chan(4'h0), hud_chan(4'h0)};
                default: hud_col_sel = '0;
            endcase
        end
    end

    logic [PW-1:0] base_p1;
    logic          hud_p1;
    logic [PW-1:0] hud_col_p1;
    logic          vid_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_p1    <= '0;
            hud_p1     <= 1'b0;
            hud_col_p1 <= '0;
            vid_p1     <= 1'b0;
        end else begin
            base_p1    <= base_sel;
            hud_p1     <= hud_sel;
            hud_col_p1 <= hud_col_sel;
            vid_p1     <= video_on;
        end
    end

    // ---- stage 2: effect, blanking and output registers ----
    logic [CW-1:0] r_nxt, g_nxt, b_nxt;

    always_comb begin
        r_nxt = base_p1[PW-1 -: CW];
        g_nxt = base_p1[2*CW-1 -: CW];
        b_nxt = base_p1[CW-1:0];
        if (!vid_p1) begin
            r_nxt = '0;
            g_nxt = '0;
            b_nxt = '0;
        end else if (hud_p1) begin
            r_nxt = hud_col_p1[PW-1 -: CW];
            g_nxt = hud_col_p1[2*CW-1 -: CW];
            b_nxt = hud_col_p1[CW-1:0];
        end else begin
            case (state)
                FLASH: r_nxt = '1;
                FADE: begin
                    r_nxt = sat_sub(base_p1[PW-1 -: CW], fade_level);
                    g_nxt = sat_sub(base_p1[2*CW-1 -: CW], fade_level);
                    b_nxt = sat_sub(base_p1[CW-1:0], fade_level);
                end
                BLACK: begin
                    r_nxt = '0;
                    g_nxt = '0;
                    b_nxt = '0;
                end
                default: ;
            endcase
        end
    end

    logic [CW-1:0] red_p2, green_p2, blue_p2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            red_p2   <= '0;
            green_p2 <= '0;
            blue_p2  <= '0;
        end else begin
            red_p2   <= r_nxt;
            green_p2 <= g_nxt;
            blue_p2  <= b_nxt;
        end
    end

    assign vga_red   = red_p2;
    assign vga_green = green_p2;
    assign vga_blue  = blue_p2;
    assign fx_state  = state;

    // Effect FSM: event inputs beat frame_start, so a frame_start in a transition cycle is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            flash_cnt  <= '0;
            step_cnt   <= '0;
            fade_level <= '0;
        end else if (fade_clr) begin
            state      <= IDLE;
            flash_cnt  <= '0;
            step_cnt   <= '0;
            fade_level <= '0;
        end else if (fade_req && (state == IDLE || state == FLASH)) begin
            state      <= FADE;
            flash_cnt  <= '0;
            step_cnt   <= '0;
            fade_level <= '0;
        end else if (hit_pulse && (state == IDLE || state == FLASH)) begin
            state     <= FLASH;
            flash_cnt <= FLASH_LOAD;
        end else if (frame_start) begin
            case (state)
                FLASH: begin
                    if (flash_cnt <= FLW'(1)) begin
                        state     <= IDLE;
                        flash_cnt <= '0;
                    end else begin
                        flash_cnt <= flash_cnt - FLW'(1);
                    end
                end
                FADE: begin
                    if (step_cnt == STEP_LAST) begin
                        step_cnt <= '0;
                        if (fade_level == LEVEL_MAX)
                            state <= BLACK;
                        else
                            fade_level <= fade_level + CW'(1);
                    end else begin
                        step_cnt <= step_cnt + STW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor with default parameters (4 layers, 4-bit channels, key 0).
module tb_layer_compositor;

    logic        clk = 1'b0;
    logic        reset;
    logic        video_on;
    logic        frame_start;
    logic [47:0] layer_pixels;
    logic [11:0] bg_pixel;
    logic [12:0] overlay_pixel;
    logic [1:0]  health_disp;
    logic        score_disp;
    logic        hit_pulse;
    logic        fade_req;
    logic        fade_clr;
    logic [3:0]  vga_red, vga_green, vga_blue;
    logic [1:0]  fx_state;
    logic [11:0] rgb;

    int n_tests = 0;
    int n_fail  = 0;

    layer_compositor dut (
        .clk           (clk),
        .reset         (reset),
        .video_on      (video_on),
        .frame_start   (frame_start),
        .layer_pixels  (layer_pixels),
        .bg_pixel      (bg_pixel),
        .overlay_pixel (overlay_pixel),
        .health_disp   (health_disp),
        .score_disp    (score_disp),
        .hit_pulse     (hit_pulse),
        .fade_req      (fade_req),
        .fade_clr      (fade_clr),
        .vga_red       (vga_red),
        .vga_green     (vga_green),
        .vga_blue      (vga_blue),
        .fx_state      (fx_state)
    );

    always #5 clk = ~clk;
    assign rgb = {vga_red, vga_green, vga_blue};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_start = 1'b1;
            step(1);
            frame_start = 1'b0;
            step(1);
        end
    endtask

    task automatic pulse_hit();
        hit_pulse = 1'b1;
        step(1);
        hit_pulse = 1'b0;
    endtask

    task automatic pulse_fade();
        fade_req = 1'b1;
        step(1);
        fade_req = 1'b0;
    endtask

    task automatic pulse_clr();
        fade_clr = 1'b1;
        step(1);
        fade_clr = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        video_on      = 1'b1;
        frame_start   = 1'b0;
        layer_pixels  = '0;
        bg_pixel      = 12'h000;
        overlay_pixel = '0;
        health_disp   = 2'b00;
        score_disp    = 1'b0;
        hit_pulse     = 1'b0;
        fade_req      = 1'b0;
        fade_clr      = 1'b0;
        step(3);
        check("reset_rgb", 32'(rgb), 32'h000);
        check("reset_fx", 32'(fx_state), 32'd0);
        reset = 1'b0;

        // Priority
        layer_pixels = {12'h000, 12'h000, 12'h123, 12'h456};
        bg_pixel     = 12'h789;
        step(1);
        check("lat_1cycle", 32'(rgb), 32'h000);
        step(1);
        check("prio_layer0", 32'(rgb), 32'h456);
        layer_pixels = {12'h000, 12'h000, 12'h123, 12'h000};
        step(2);
        check("prio_layer1", 32'(rgb), 32'h123);
        layer_pixels = '0;
        step(2);
        check("prio_bg", 32'(rgb), 32'h789);
        layer_pixels  = {12'h000, 12'h000, 12'h123, 12'h456};
        overlay_pixel = {1'b1, 12'hABC};
        step(2);
        check("prio_overlay", 32'(rgb), 32'hABC);
        overlay_pixel = '0;
        layer_pixels  = '0;

        // HUD and blanking
        score_disp  = 1'b1;
        health_disp = 2'b11;
        step(2);
        check("hud_score", 32'(rgb), 32'hDC0);
        score_disp  = 1'b0;
        health_disp = 2'b10;
        step(2);
        check("hud_health10", 32'(rgb), 32'hD80);
        health_disp = 2'b01;
        step(2);
        check("hud_health01", 32'(rgb), 32'hF00);
        health_disp = 2'b11;
        step(2);
        check("hud_health11", 32'(rgb), 32'h0F0);
        score_disp = 1'b1;
        step(2);
        video_on = 1'b0;
        step(1);
        check("blank_lat1", 32'(rgb), 32'hDC0);
        step(1);
        check("blank_lat2", 32'(rgb), 32'h000);
        video_on    = 1'b1;
        score_disp  = 1'b0;
        health_disp = 2'b00;

        // Flash
        bg_pixel = 12'h345;
        step(2);
        check("flash_pre", 32'(rgb), 32'h345);
        pulse_hit();
        check("flash_state", 32'(fx_state), 32'd1);
        step(1);
        check("flash_red", 32'(rgb), 32'hF45);
        health_disp = 2'b11;
        step(2);
        check("flash_hud", 32'(rgb), 32'h0F0);
        health_disp = 2'b00;
        frames(7);
        check("flash_7frames", 32'(fx_state), 32'd1);
        check("flash_7_red", 32'(rgb), 32'hF45);
        frames(1);
        check("flash_8frames", 32'(fx_state), 32'd0);
        step(1);
        check("flash_done_rgb", 32'(rgb), 32'h345);
        pulse_hit();
        frames(3);
        pulse_hit();
        frames(7);
        check("rehit_7", 32'(fx_state), 32'd1);
        frames(1);
        check("rehit_8", 32'(fx_state), 32'd0);

        // Fade
        bg_pixel = 12'h888;
        step(2);
        pulse_fade();
        check("fade_state", 32'(fx_state), 32'd2);
        step(1);
        check("fade_lvl0", 32'(rgb), 32'h888);
        frames(3);
        check("fade_3frames", 32'(rgb), 32'h888);
        frames(1);
        check("fade_4frames", 32'(rgb), 32'h777);
        frames(16);
        check("fade_lvl5", 32'(rgb), 32'h333);
        frames(28);
        check("fade_sat", 32'(rgb), 32'h000);
        health_disp = 2'b10;
        step(2);
        check("fade_hud", 32'(rgb), 32'hD80);
        health_disp = 2'b00;
        frames(12);
        check("fade_60", 32'(fx_state), 32'd2);
        frames(4);
        check("black_64", 32'(fx_state), 32'd3);
        pulse_hit();
        check("black_ignore_hit", 32'(fx_state), 32'd3);
        step(1);
        check("black_rgb", 32'(rgb), 32'h000);
        pulse_clr();
        check("clr_state", 32'(fx_state), 32'd0);
        step(1);
        check("clr_rgb", 32'(rgb), 32'h888);

        // Simultaneous events
        fade_req  = 1'b1;
        hit_pulse = 1'b1;
        step(1);
        fade_req  = 1'b0;
        hit_pulse = 1'b0;
        check("req_beats_hit", 32'(fx_state), 32'd2);
        fade_req = 1'b1;
        fade_clr = 1'b1;
        step(1);
        fade_req = 1'b0;
        fade_clr = 1'b0;
        check("clr_beats_req", 32'(fx_state), 32'd0);

        // Reset during fade at level 5
        pulse_fade();
        frames(20);
        step(1);
        check("pre_reset_lvl5", 32'(rgb), 32'h333);
        reset = 1'b1;
        #1;
        check("rst_async_rgb", 32'(rgb), 32'h000);
        check("rst_async_fx", 32'(fx_state), 32'd0);
        step(2);
        reset = 1'b0;
        step(1);
        check("post_rst_lat1", 32'(rgb), 32'h000);
        step(1);
        check("post_rst_rgb", 32'(rgb), 32'h888);
        check("post_rst_fx", 32'(fx_state), 32'd0);
        frames(4);
        check("post_rst_nofade", 32'(rgb), 32'h888);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
